wide_add_seq: RTL and testbench

Multi-cycle wide-operand adder/subtractor controller. It accepts one `32*WORDS`-bit operation per handshake and sequences it word-serially through a single 32-bit carry-select adder instance (`CSA32`), least-significant word first. A carry register chains each word into the next. It sits between a control/ALU front end and the shared 32-bit adder datapath, so the design gets 64/128-bit arithmetic without replicating adders.

---
 rtl/wide_add_seq.sv | 167 ++++++++++++++++
 tb/tb_wide_add_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : wide_add_seq
//  Purpose  : Word-serial wide adder/subtractor. One 32*WORDS-bit operation
//             is sequenced LSW first through a single 32-bit carry-select
//             adder, with a carry register chaining adjacent words.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  csa32 : 32-bit carry-select adder. Low half ripples; the high half is
//  precomputed for both possible mid carries and selected by the real one.
// ----------------------------------------------------------------------------
module csa32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        co
);
   logic [16:0] lo;
   logic [16:0] hi0;
   logic [16:0] hi1;

   assign lo  = {1'b0, a[15:0]}  + {1'b0, b[15:0]}  + 17'(cin);
   assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
   assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

   assign s  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
   assign co = lo[16] ? hi1[16] : hi0[16];
endmodule

// ----------------------------------------------------------------------------
//  wide_add_seq : controller around the shared csa32
// ----------------------------------------------------------------------------
module wide_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic [32*WORDS-1:0]   a,
   input  logic [32*WORDS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [32*WORDS-1:0]   sum,
   output logic                  cout,
   output logic                  ovf
);
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [KW-1:0]       k;
   logic                carry;
   logic                op_sub;
   logic [31:0]         op_a [WORDS];
   logic [31:0]         op_b [WORDS];
   logic [31:0]         work [WORDS];

   logic [32*WORDS-1:0] sum_r;
   logic                cout_r;
   logic                ovf_r;
   logic                done_r;

   logic [31:0]         add_a;
   logic [31:0]         add_b;
   logic [31:0]         add_s;
   logic                add_co;
   logic                last;

   // Current word feeds the shared adder; B is inverted for subtraction so
   // that A - B - cin becomes A + ~B + ~cin (the ~cin lives in the carry reg).
   assign add_a = op_a[k];
   assign add_b = op_b[k] ^ {32{op_sub}};
   assign last  = (k == K_LAST);

   csa32 u_csa32 (
      .a   (add_a),
      .b   (add_b),
      .cin (carry),
      .s   (add_s),
      .co  (add_co)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, leave RUN after the last word
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, word-serial accumulation, result publish
   always_ff @(posedge clk) begin
      if (rst) begin
         k      <= '0;
         carry  <= 1'b0;
         op_sub <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            op_a[i] <= '0;
            op_b[i] <= '0;
            work[i] <= '0;
         end
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < WORDS; i++) begin
                     op_a[i] <= a[32*i +: 32];
                     op_b[i] <= b[32*i +: 32];
                  end
                  op_sub <= sub;
                  k      <= '0;
                  carry  <= cin ^ sub;
               end
            end
            RUN: begin
               work[k] <= add_s;
               carry   <= add_co;
               k       <= k + 1'b1;
               if (last) begin
                  // The word just produced is not yet in work[], so splice
                  // it in directly as the most significant word.
                  for (int i = 0; i < WORDS - 1; i++)
                     sum_r[32*i +: 32] <= work[i];
                  sum_r[32*(WORDS-1) +: 32] <= add_s;
                  cout_r <= add_co;
                  ovf_r  <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
                  done_r <= 1'b1;
                  k      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;
endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wide_add_seq
//  Purpose  : Directed self-checking bench for wide_add_seq (WORDS=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [127:0] a = '0;
   logic [127:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [127:0] sum;
   logic         cout;
   logic         ovf;

   int tests  = 0;
   int failed = 0;

   wide_add_seq #(.WORDS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " sum"},  sum,  0);
      chk({tag, " cout"}, cout, 0);
      chk({tag, " ovf"},  ovf,  0);
   endtask

   // Launch one op from an IDLE cycle and check the full timeline to done.
   task automatic do_op(input string tag, input logic [127:0] va, input logic [127:0] vb,
                        input logic vsub, input logic vcin,
                        input logic [127:0] esum, input logic ecout, input logic eovf);
      a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("%s busy c%0d", tag, i), busy, 1);
         chk($sformatf("%s done c%0d", tag, i), done, 0);
         step();
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " busy@done"}, busy, 0);
      chk({tag, " sum"},  sum,  esum);
      chk({tag, " cout"}, cout, ecout);
      chk({tag, " ovf"},  ovf,  eovf);
      step();
      chk({tag, " done pulse"}, done, 0);
      chk({tag, " sum hold"},   sum,  esum);
   endtask

   initial begin
      // ---- reset with start held high ----
      rst = 1'b1; start = 1'b1; a = 128'd9; b = 128'd9;
      step(); chk_idle_zero("rst1");
      step(); chk_idle_zero("rst2");
      rst = 1'b0; start = 1'b0;
      step(); chk_idle_zero("post_rst");

      // ---- carry ripple ----
      do_op("ripple", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
            128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);

      // ---- full wrap ----
      do_op("wrap", {128{1'b1}}, 128'd0, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0);
      do_op("posovf", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
            128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);

      // ---- subtract ----
      do_op("sub0m1", 128'd0, 128'd1, 1'b1, 1'b0, {128{1'b1}}, 1'b0, 1'b0);
      do_op("subneg", 128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1, 1'b0,
            128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1);
      do_op("sub5", 128'd5, 128'd2, 1'b1, 1'b1, 128'd2, 1'b1, 1'b0);

      // ---- handshake: ignored start mid-run, back-to-back accept ----
      a = 128'd10; b = 128'd20; sub = 1'b0; cin = 1'b0; start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      chk("hs busy c1", busy, 1);
      step();                                   // cycle 2
      a = 128'd1000; b = 128'd1; sub = 1'b1; start = 1'b1;
      chk("hs busy c2", busy, 1);
      step();                                   // cycle 3
      a = 128'd2000; b = 128'd7; sub = 1'b0; cin = 1'b1;
      chk("hs busy c3", busy, 1);
      step();                                   // cycle 4
      start = 1'b0;
      chk("hs busy c4", busy, 1);
      chk("hs done c4", done, 0);
      step();                                   // cycle 5
      chk("hs done c5", done, 1);
      chk("hs busy c5", busy, 0);
      chk("hs sum1",  sum,  128'd30);
      chk("hs cout1", cout, 0);
      a = 128'd3; b = 128'd4; sub = 1'b0; cin = 1'b0; start = 1'b1;
      step();                                   // cycle 6
      start = 1'b0;
      for (int c = 6; c <= 9; c++) begin
         chk($sformatf("hs busy c%0d", c), busy, 1);
         chk($sformatf("hs done c%0d", c), done, 0);
         chk($sformatf("hs sum stable c%0d", c), sum, 128'd30);
         step();
      end
      chk("hs done c10", done, 1);
      chk("hs sum2", sum, 128'd7);
      step();

      // ---- reset mid-operation ----
      a = 128'd100; b = 128'd200; sub = 1'b0; cin = 1'b0; start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      chk("mid busy c1", busy, 1);
      step();                                   // cycle 2
      rst = 1'b1;
      step();                                   // cycle 3
      rst = 1'b0;
      chk_idle_zero("mid c3");
      a = 128'd1; b = 128'd2;
      step();                                   // cycle 4
      chk_idle_zero("mid c4");
      do_op("after_abort", 128'd1, 128'd2, 1'b0, 1'b0, 128'd3, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
